// File: rtl/seg_scan_if.sv
// Handshake and display bundle between a host and the four-digit scan driver.
interface seg_scan_if;
  logic [13:0] value;
  logic        load;
  logic        blank_lz;
  logic        busy;
  logic [3:0]  num;
  logic [3:0]  an;

  modport master (
    output value, load, blank_lz,
    input  busy, num, an
  );

  modport slave (
    input  value, load, blank_lz,
    output busy, num, an
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Four-digit scan driver: sequential double-dabble binary-to-BCD conversion followed by
// time-multiplexed presentation of the digits with optional leading-zero blanking.
module seg_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  seg_scan_if.slave  bus
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(REFRESH_DIV - 1);

  logic [PW-1:0]     presc_q, presc_d;
  logic [1:0]        idx_q, idx_d;
  logic              busy_q, busy_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [29:0]       sh_q, sh_d;
  logic              ovf_q, ovf_d;
  logic [3:0][3:0]   dig_q, dig_d;

  logic [29:0]       sh_adj;
  logic [3:0]        blank;

  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PrescMax) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end
  end

  // Add-3 correction on every BCD nibble before the shift.
  always_comb begin
    sh_adj = sh_q;
    for (int i = 0; i < 4; i++) begin
      if (sh_q[14 + 4*i +: 4] >= 4'd5) begin
        sh_adj[14 + 4*i +: 4] = sh_q[14 + 4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    ovf_d  = ovf_q;
    dig_d  = dig_q;
    if (busy_q) begin
      sh_d  = sh_adj << 1;
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        busy_d = 1'b0;
        for (int i = 0; i < 4; i++) begin
          dig_d[i] = ovf_q ? 4'hF : sh_d[14 + 4*i +: 4];
        end
      end
    end else if (bus.load) begin
      sh_d   = {16'h0000, bus.value};
      cnt_d  = 4'd14;
      busy_d = 1'b1;
      ovf_d  = (bus.value > 14'd9999);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= 2'd0;
      busy_q  <= 1'b0;
      cnt_q   <= 4'd0;
      sh_q    <= '0;
      ovf_q   <= 1'b0;
      dig_q   <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ovf_q   <= ovf_d;
      dig_q   <= dig_d;
    end
  end

  // A digit blanks only when it and every digit above it are zero; the ones digit never blanks.
  always_comb begin
    blank[3] = bus.blank_lz && (dig_q[3] == 4'd0);
    blank[2] = blank[3] && (dig_q[2] == 4'd0);
    blank[1] = blank[2] && (dig_q[1] == 4'd0);
    blank[0] = 1'b0;
  end

  always_comb begin
    bus.busy = busy_q;
    bus.an   = ~(4'b0001 << idx_q);
    bus.num  = blank[idx_q] ? 4'hF : dig_q[idx_q];
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: table vectors, hand-written corner sequences and
// randomized loads, all compared against an arithmetic model of the displayed value.
module tb_seg_scan_driver;

  localparam int unsigned Div = 4;

  logic clk;
  logic rst_n;

  seg_scan_if bus ();

  seg_scan_driver #(.REFRESH_DIV(Div)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model state: edges since reset release, committed value, pending conversion.
  int unsigned cyc      = 0;
  int unsigned disp_val = 0;
  int unsigned pend_val = 0;
  int unsigned m_rem    = 0;
  bit          m_busy   = 1'b0;

  typedef struct {
    int unsigned value;
    logic        blz;
    logic [15:0] exp;   // nibble k = expected num while idx = k
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  function automatic int unsigned model_idx();
    return (cyc / Div) % 4;
  endfunction

  function automatic logic [3:0] exp_num(input int unsigned k);
    int unsigned p;
    p = 1;
    for (int i = 0; i < int'(k); i++) p = p * 10;
    if (disp_val > 9999) return 4'hF;
    if (bus.blank_lz && k > 0 && disp_val < p) return 4'hF;
    return 4'((disp_val / p) % 10);
  endfunction

  task automatic model_reset();
    cyc      = 0;
    disp_val = 0;
    m_busy   = 1'b0;
    m_rem    = 0;
  endtask

  task automatic check_outputs();
    logic [3:0] one;
    one = 4'b0001;
    check("busy", {3'b000, bus.busy}, {3'b000, m_busy});
    check("an", bus.an, ~(one << model_idx()));
    check("num", bus.num, exp_num(model_idx()));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      cyc++;
      if (m_busy) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy   = 1'b0;
          disp_val = pend_val;
        end
      end else if (bus.load) begin
        m_busy   = 1'b1;
        m_rem    = 14;
        pend_val = bus.value;
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    while (bus.busy && n < 20) begin
      tick();
      n++;
    end
    check("idle_timeout", {3'b000, bus.busy}, 4'd0);
  endtask

  task automatic do_load(input int unsigned v);
    bus.value = 14'(v);
    bus.load  = 1'b1;
    tick();
    bus.load  = 1'b0;
  endtask

  initial begin
    vecs[0] = '{value: 1234,  blz: 1'b0, exp: 16'h1234};
    vecs[1] = '{value: 7,     blz: 1'b1, exp: 16'hFFF7};
    vecs[2] = '{value: 7,     blz: 1'b0, exp: 16'h0007};
    vecs[3] = '{value: 0,     blz: 1'b1, exp: 16'hFFF0};
    vecs[4] = '{value: 1005,  blz: 1'b0, exp: 16'h1005};
    vecs[5] = '{value: 1005,  blz: 1'b1, exp: 16'h1005};
    vecs[6] = '{value: 10000, blz: 1'b0, exp: 16'hFFFF};
    vecs[7] = '{value: 9999,  blz: 1'b1, exp: 16'h9999};
    vecs[8] = '{value: 16383, blz: 1'b1, exp: 16'hFFFF};
    vecs[9] = '{value: 50,    blz: 1'b1, exp: 16'hFF50};

    rst_n        = 1'b0;
    bus.load     = 1'b0;
    bus.value    = '0;
    bus.blank_lz = 1'b0;
    #1;
    check("reset_an", bus.an, 4'b1110);
    check("reset_num", bus.num, 4'h0);
    check("reset_busy", {3'b000, bus.busy}, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Scan from reset: first advance at edge Div.
    for (int i = 0; i < 2 * Div; i++) tick();

    // Table-driven loads with explicit busy timing and per-digit expectations.
    foreach (vecs[v]) begin
      wait_idle();
      bus.blank_lz = vecs[v].blz;
      do_load(vecs[v].value);
      check("busy_rise", {3'b000, bus.busy}, 4'd1);
      for (int i = 0; i < 13; i++) tick();
      check("busy_hold", {3'b000, bus.busy}, 4'd1);
      tick();
      check("busy_fall", {3'b000, bus.busy}, 4'd0);
      for (int i = 0; i < 4 * Div; i++) begin
        int unsigned k;
        logic [15:0] e;
        k = model_idx();
        e = vecs[v].exp;
        check("table_num", bus.num, e[4*k +: 4]);
        tick();
      end
    end

    // blank_lz acts without a clock edge: show 7 and toggle blanking on the tens digit.
    wait_idle();
    bus.blank_lz = 1'b1;
    do_load(7);
    for (int i = 0; i < 14; i++) tick();
    begin
      int unsigned n;
      n = 0;
      while (model_idx() != 1 && n < 20) begin
        tick();
        n++;
      end
    end
    check("blank_idx", bus.an, 4'b1101);
    check("blank_on", bus.num, 4'hF);
    bus.blank_lz = 1'b0;
    #1;
    check("blank_off_comb", bus.num, 4'h0);
    bus.blank_lz = 1'b1;
    #1;
    check("blank_on_comb", bus.num, 4'hF);

    // Load while busy is dropped; a load right after busy falls is taken.
    wait_idle();
    bus.blank_lz = 1'b0;
    do_load(42);
    tick();
    tick();
    do_load(999);
    for (int i = 0; i < 11; i++) tick();
    check("ignored_busy", {3'b000, bus.busy}, 4'd0);
    for (int i = 0; i < 4 * Div; i++) tick();
    do_load(77);
    check("next_load_taken", {3'b000, bus.busy}, 4'd1);
    for (int i = 0; i < 14 + 4 * Div; i++) tick();

    // Asynchronous reset mid-scan, no clock needed.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_an", bus.an, 4'b1110);
    check("async_num", bus.num, 4'h0);
    check("async_busy", {3'b000, bus.busy}, 4'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();

    // Reset seven cycles into a conversion aborts it; load during release is captured.
    wait_idle();
    do_load(8765);
    for (int i = 0; i < 6; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {3'b000, bus.busy}, 4'd0);
    check("abort_num", bus.num, 4'h0);
    model_reset();
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("abort_hold_num", bus.num, 4'h0);
    for (int i = 0; i < 4 * Div; i++) tick();
    @(negedge clk);
    bus.value = 14'd321;
    bus.load  = 1'b1;
    rst_n     = 1'b1;
    tick();
    bus.load  = 1'b0;
    check("release_load", {3'b000, bus.busy}, 4'd1);
    for (int i = 0; i < 14 + 4 * Div; i++) tick();

    // Randomized loads, gaps and blank_lz activity against the model.
    for (int r = 0; r < 40; r++) begin
      int unsigned v;
      int unsigned gap;
      wait_idle();
      case ($urandom_range(0, 5))
        0:       v = $urandom_range(0, 9);
        1:       v = $urandom_range(9990, 10010);
        2:       v = $urandom_range(10000, 16383);
        default: v = $urandom_range(0, 9999);
      endcase
      bus.blank_lz = 1'($urandom_range(0, 1));
      do_load(v);
      gap = $urandom_range(14, 30);
      for (int i = 0; i < int'(gap); i++) begin
        if ($urandom_range(0, 7) == 0) bus.blank_lz = ~bus.blank_lz;
        if ($urandom_range(0, 5) == 0) begin
          bus.value = 14'($urandom_range(0, 16383));
          bus.load  = 1'b1;
        end
        tick();
        bus.load = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
